// File: rtl/beam_input_capture_if.sv
`default_nettype none
// ============================================================================
// beam_input_capture_if
// Avalon-MM slave register bus used by beam_input_capture.
// Revision: 1.0
// ============================================================================
interface beam_input_capture_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/beam_input_capture.sv
`default_nettype none
// ============================================================================
// beam_input_capture
// Synchronised, debounced beam/button inputs with per-channel edge capture,
// interrupt masking and an Avalon-MM register window.
// Revision: 1.0
// ============================================================================
module beam_input_capture #(
    parameter int CHANNELS        = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    input  wire logic [CHANNELS-1:0] in_raw,
    beam_input_capture_if.slave      bus,
    output logic                     irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_SEL  = 2'd3;

    logic [CHANNELS-1:0] sync_meta;
    logic [CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0] stable;
    logic [CHANNELS-1:0] stable_nx;
    logic [CHANNELS-1:0] edge_det;
    logic [CHANNELS-1:0] edge_capture;
    logic [CHANNELS-1:0] irq_mask;
    logic [CHANNELS-1:0] edge_sel;
    logic [CHANNELS-1:0] wdata;
    logic [CHANNELS-1:0] w1c;
    logic [31:0]         rd_mux;
    logic                wr_mask;
    logic                wr_sel;
    logic                unused_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= in_raw;
            sync_q    <= sync_meta;
        end
    end

    // Each channel owns its debounce counter; stable flips on the cycle the
    // count would reach DEBOUNCE_CYCLES, so the counter never exceeds CNT_LAST.
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        logic [CNT_W-1:0] cnt;
        logic             flip;

        assign flip = (sync_q[ch] != stable[ch]) && (cnt == CNT_LAST);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt        <= '0;
                stable[ch] <= 1'b0;
            end else if (sync_q[ch] == stable[ch]) begin
                cnt <= '0;
            end else if (flip) begin
                cnt        <= '0;
                stable[ch] <= ~stable[ch];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign stable_nx[ch] = stable[ch] ^ flip;
        assign edge_det[ch]  = edge_sel[ch] ? (stable[ch] & ~stable_nx[ch])
                                            : (~stable[ch] & stable_nx[ch]);
    end

    assign wdata        = bus.writedata[CHANNELS-1:0];
    assign unused_wdata = ^bus.writedata;
    assign wr_mask      = bus.write && (bus.address == ADDR_MASK);
    assign wr_sel       = bus.write && (bus.address == ADDR_SEL);
    assign w1c          = (bus.write && (bus.address == ADDR_EDGE)) ? wdata : '0;

    // Read mux looks at current register contents, so a same-cycle write
    // is not visible until the following read.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA: rd_mux[CHANNELS-1:0] = stable;
            ADDR_MASK: rd_mux[CHANNELS-1:0] = irq_mask;
            ADDR_EDGE: rd_mux[CHANNELS-1:0] = edge_capture;
            ADDR_SEL:  rd_mux[CHANNELS-1:0] = edge_sel;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_sel     <= '0;
            edge_capture <= '0;
            irq          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            if (wr_mask) begin
                irq_mask <= wdata;
            end
            if (wr_sel) begin
                edge_sel <= wdata;
            end
            // A fresh edge outranks a coincident clear of the same bit.
            edge_capture <= (edge_capture & ~w1c) | edge_det;
            irq          <= |(edge_capture & irq_mask);
            if (bus.read) begin
                bus.readdata <= rd_mux;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_beam_input_capture.sv
`default_nettype none
// ============================================================================
// tb_beam_input_capture
// Directed self-checking bench, CHANNELS=8, DEBOUNCE_CYCLES=4.
// Revision: 1.0
// ============================================================================
module tb_beam_input_capture;

    localparam int CHANNELS        = 8;
    localparam int DEBOUNCE_CYCLES = 4;

    logic                clk;
    logic                reset_n;
    logic [CHANNELS-1:0] in_raw;
    logic                irq;
    int                  n_checks;
    int                  n_pass;
    logic [31:0]         rd;

    beam_input_capture_if bus ();

    beam_input_capture #(
        .CHANNELS        (CHANNELS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_raw  (in_raw),
        .bus     (bus),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus.address   = addr;
        bus.writedata = data;
        bus.write     = 1'b1;
        tick();
        bus.write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        bus.address = addr;
        bus.read    = 1'b1;
        tick();
        bus.read    = 1'b0;
        data        = bus.readdata;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        reset_n       = 1'b0;
        in_raw        = '0;
        bus.address   = '0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = '0;

        repeat (3) tick();
        check("reset_readdata", bus.readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            check($sformatf("reset_reg%0d", a), rd, 32'h0);
        end

        // ch0 rising: stable must flip on exactly the 6th edge
        in_raw[0] = 1'b1;
        repeat (5) tick();
        bus_read(0, rd);
        check("data0_before", rd, 32'h0);
        bus_read(0, rd);
        check("data0_after", rd, 32'h1);
        bus_read(2, rd);
        check("cap_ch0", rd, 32'h1);
        check("irq_masked", {31'b0, irq}, 32'h0);

        // high mask bits ignored, clear capture, then a fresh edge raises irq
        bus_write(1, 32'hFFFF_FF01);
        bus_read(1, rd);
        check("mask_width", rd, 32'h1);
        bus_write(2, 32'h1);
        bus_read(2, rd);
        check("w1c_ch0", rd, 32'h0);
        in_raw[0] = 1'b0;
        repeat (8) tick();
        bus_read(2, rd);
        check("fall_no_cap", rd, 32'h0);
        check("irq_idle", {31'b0, irq}, 32'h0);
        in_raw[0] = 1'b1;
        repeat (6) tick();
        check("irq_at_cap", {31'b0, irq}, 32'h0);
        tick();
        check("irq_after_cap", {31'b0, irq}, 32'h1);
        bus_write(2, 32'h1);
        check("irq_clr_edge", {31'b0, irq}, 32'h1);
        tick();
        check("irq_cleared", {31'b0, irq}, 32'h0);
        bus_read(2, rd);
        check("cap_cleared", rd, 32'h0);

        // 3-clock glitch on ch3 is rejected; DATA writes ignored
        in_raw[3] = 1'b1;
        repeat (3) tick();
        in_raw[3] = 1'b0;
        repeat (10) tick();
        bus_write(0, 32'hFF);
        bus_read(0, rd);
        check("glitch_data", rd, 32'h1);
        bus_read(2, rd);
        check("glitch_cap", rd, 32'h0);

        // same-cycle read+write of EDGE_SEL returns the old value
        bus.address   = 2'd3;
        bus.writedata = 32'h80;
        bus.read      = 1'b1;
        bus.write     = 1'b1;
        tick();
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        check("rw_pre_write", bus.readdata, 32'h0);
        bus_read(3, rd);
        check("sel_written", rd, 32'h80);

        // ch7 falling-edge select
        in_raw[7] = 1'b1;
        repeat (8) tick();
        bus_read(2, rd);
        check("ch7_rise_ignored", rd, 32'h0);
        in_raw[7] = 1'b0;
        repeat (8) tick();
        bus_read(2, rd);
        check("ch7_fall_cap", rd, 32'h80);
        bus_write(2, 32'h80);
        in_raw[7] = 1'b1;
        repeat (8) tick();
        bus_read(2, rd);
        check("ch7_rise_nocap", rd, 32'h0);
        bus_read(0, rd);
        check("data_ch0_ch7", rd, 32'h81);

        // ch2 edge coinciding with a W1C of bit 2: set wins
        in_raw[2] = 1'b1;
        repeat (5) tick();
        bus_write(2, 32'h4);
        bus_read(2, rd);
        check("set_wins", rd, 32'h4);

        // reset mid-debounce on ch5
        bus_write(1, 32'h4);
        tick();
        check("irq_ch2", {31'b0, irq}, 32'h1);
        in_raw[5] = 1'b1;
        repeat (4) tick();
        reset_n = 1'b0;
        #2;
        check("async_readdata", bus.readdata, 32'h0);
        check("async_irq", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            check($sformatf("post_reset_reg%0d", a), rd, 32'h0);
        end
        tick();
        bus_read(2, rd);
        check("cap_before_full", rd, 32'h0);
        bus_read(2, rd);
        check("cap_after_full", rd, 32'hA5);
        bus_read(0, rd);
        check("data_after_reset", rd, 32'hA5);
        check("irq_after_reset", {31'b0, irq}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
